bank_cmd_gate: RTL and testbench

BANK_CMD_GATE -- requirements
Module: bank_cmd_gate

---
 rtl/bank_cmd_gate_pkg.sv | 39 +++
 rtl/bank_cmd_gate_legal_chk.sv | 41 ++++
 rtl/bank_cmd_gate.sv | 144 ++++++++++++++
 tb/tb_bank_cmd_gate.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_cmd_gate_pkg.sv
// Shared types for the bank command gate: command/recode encodings, gate states, abort codes.
package bank_cmd_gate_pkg;

  localparam logic [2:0] CMD_ACT   = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [2:0] CMD_WRITE = 3'd3;
  localparam logic [2:0] CMD_PRE   = 3'd4;
  localparam logic [2:0] CMD_REF   = 3'd5;

  localparam logic [2:0] RC_IDLE    = 3'd0;
  localparam logic [2:0] RC_WR2PRE  = 3'd1;
  localparam logic [2:0] RC_PRE2ACT = 3'd2;
  localparam logic [2:0] RC_ACT2RW  = 3'd3;
  localparam logic [2:0] RC_RD2PRE  = 3'd4;
  localparam logic [2:0] RC_PRE2REF = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_ERR   = 2'd3
  } gate_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_e;

  // Codes 5 and 6 are neither open nor closed; they make bank-state-dependent commands illegal.
  function automatic logic rc_closed(input logic [2:0] rc);
    return (rc == RC_IDLE) || (rc == RC_PRE2ACT) || (rc == RC_PRE2REF);
  endfunction

  function automatic logic rc_open(input logic [2:0] rc);
    return (rc == RC_WR2PRE) || (rc == RC_ACT2RW) || (rc == RC_RD2PRE);
  endfunction

endpackage

// File: rtl/bank_cmd_gate_legal_chk.sv
// Combinational legality verdict for the latched command against one bank's timing state.
module bank_legal_chk
  import bank_cmd_gate_pkg::*;
(
  input  logic [2:0] cmd_type,
  input  logic       bank_ok,
  input  logic [4:0] cnt,
  input  logic [5:0] tras,
  input  logic [2:0] rc,
  input  logic       ref_all_closed,
  input  logic       ref_all_idle,
  output logic       legal,
  output logic       illegal
);

  always_comb begin
    legal   = 1'b0;
    illegal = 1'b0;
    if (!bank_ok) begin
      illegal = 1'b1;
    end else begin
      case (cmd_type)
        CMD_ACT: begin
          if (rc_closed(rc)) legal = (cnt == 5'd0);
          else               illegal = 1'b1;
        end
        CMD_READ, CMD_WRITE: begin
          if (rc_open(rc)) legal = (rc != RC_ACT2RW) || (cnt == 5'd0);
          else             illegal = 1'b1;
        end
        CMD_PRE: legal = (cnt == 5'd0) && (tras == 6'd0);
        CMD_REF: begin
          if (ref_all_closed) legal = ref_all_idle;
          else                illegal = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/bank_cmd_gate.sv
// Holds one upstream DRAM command until its bank timing allows it, then issues or aborts it.
//   state | meaning
//   IDLE  | ready for a new command
//   HOLD  | command latched, waiting for bank timing to permit it
//   ISSUE | command presented downstream until issue_ready
//   ERR   | one-cycle abort pulse, command dropped
module bank_cmd_gate
  import bank_cmd_gate_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int BA_BITS   = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_type,
  input  logic [BA_BITS-1:0]     cmd_bank,
  input  logic [NUM_BANKS*5-1:0] tp_cnt_flat,
  input  logic [NUM_BANKS*6-1:0] tras_cnt_flat,
  input  logic [NUM_BANKS*3-1:0] recode_flat,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [2:0]             issue_type,
  output logic [BA_BITS-1:0]     issue_bank,
  output logic                   err_valid,
  output logic [1:0]             err_code,
  output logic [15:0]            stall_cnt
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam int BA_W1 = BA_BITS + 1;

  gate_state_e          state, state_nxt;
  logic [2:0]           lat_type;
  logic [BA_BITS-1:0]   lat_bank;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [15:0]          stall_q;
  err_code_e            err_code_q, err_nxt;
  logic                 err_set, wait_inc, rdy_en, accept;

  logic [4:0]           tp_cnt   [NUM_BANKS];
  logic [5:0]           tras_cnt [NUM_BANKS];
  logic [2:0]           recode   [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_closed, bank_idle;

  logic                 bank_ok, legal, illegal;
  logic [4:0]           sel_cnt;
  logic [5:0]           sel_tras;
  logic [2:0]           sel_rc;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign tp_cnt[b]      = tp_cnt_flat[5*b +: 5];
    assign tras_cnt[b]    = tras_cnt_flat[6*b +: 6];
    assign recode[b]      = recode_flat[3*b +: 3];
    assign bank_closed[b] = rc_closed(recode[b]);
    assign bank_idle[b]   = (tp_cnt[b] == 5'd0);
  end

  // Zero-extend before comparing so out-of-range banks are caught even when BA_BITS spans exactly NUM_BANKS.
  assign bank_ok  = {1'b0, lat_bank} < BA_W1'(NUM_BANKS);
  assign sel_cnt  = bank_ok ? tp_cnt[lat_bank]   : '0;
  assign sel_tras = bank_ok ? tras_cnt[lat_bank] : '0;
  assign sel_rc   = bank_ok ? recode[lat_bank]   : '0;

  bank_legal_chk u_chk (
    .cmd_type       (lat_type),
    .bank_ok        (bank_ok),
    .cnt            (sel_cnt),
    .tras           (sel_tras),
    .rc             (sel_rc),
    .ref_all_closed (&bank_closed),
    .ref_all_idle   (&bank_idle),
    .legal          (legal),
    .illegal        (illegal)
  );

  // rdy_en keeps cmd_ready low until the first clock after reset release.
  assign cmd_ready   = (state == ST_IDLE) && rdy_en;
  assign accept      = cmd_valid && cmd_ready;
  assign issue_valid = (state == ST_ISSUE);
  assign err_valid   = (state == ST_ERR);
  assign issue_type  = lat_type;
  assign issue_bank  = lat_bank;
  assign err_code    = err_code_q;
  assign stall_cnt   = stall_q;

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    err_nxt   = ERR_ILLEGAL;
    wait_inc  = 1'b0;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (legal) begin
          state_nxt = ST_ISSUE;
        end else if (illegal) begin
          state_nxt = ST_ERR;
          err_set   = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_ERR;
          err_set   = 1'b1;
          err_nxt   = ERR_TIMEOUT;
        end else begin
          wait_inc  = 1'b1;
        end
      end
      ST_ISSUE: if (issue_ready) state_nxt = ST_IDLE;
      ST_ERR:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_type   <= '0;
      lat_bank   <= '0;
      wait_cnt   <= '0;
      stall_q    <= '0;
      err_code_q <= ERR_NONE;
      rdy_en     <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        lat_type <= cmd_type;
        lat_bank <= cmd_bank;
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == ST_HOLD && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (err_set) err_code_q <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bank_cmd_gate.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic against a behavioural model.
module tb_bank_cmd_gate;

  localparam int NB = 8;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_type = '0;
  logic [2:0]  cmd_bank = '0;
  logic [39:0] tp_cnt_flat = '0;
  logic [47:0] tras_cnt_flat = '0;
  logic [23:0] recode_flat = '0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [2:0]  issue_type;
  logic [2:0]  issue_bank;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  bit m_rdy = 0, m_pend = 0, m_iss = 0, m_err = 0;
  int m_type = 0, m_bank = 0, m_wait = 0, m_stall = 0, m_code = 0;

  bank_cmd_gate #(.NUM_BANKS(NB), .BA_BITS(3), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_type      (cmd_type),
    .cmd_bank      (cmd_bank),
    .tp_cnt_flat   (tp_cnt_flat),
    .tras_cnt_flat (tras_cnt_flat),
    .recode_flat   (recode_flat),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_type    (issue_type),
    .issue_bank    (issue_bank),
    .err_valid     (err_valid),
    .err_code      (err_code),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int rc_of(int b);
    return int'(recode_flat[3*b +: 3]);
  endfunction
  function automatic int cnt_of(int b);
    return int'(tp_cnt_flat[5*b +: 5]);
  endfunction
  function automatic int tras_of(int b);
    return int'(tras_cnt_flat[6*b +: 6]);
  endfunction
  function automatic bit is_closed(int rc);
    return rc inside {0, 2, 7};
  endfunction
  function automatic bit is_open(int rc);
    return rc inside {1, 3, 4};
  endfunction

  // +1 legal, -1 illegal, 0 keep waiting
  function automatic int verdict(int t, int b);
    int all_zero;
    if (b >= NB) return -1;
    case (t)
      1: begin
        if (!is_closed(rc_of(b))) return -1;
        return (cnt_of(b) == 0) ? 1 : 0;
      end
      2, 3: begin
        if (!is_open(rc_of(b))) return -1;
        return (rc_of(b) != 3 || cnt_of(b) == 0) ? 1 : 0;
      end
      4: return (cnt_of(b) == 0 && tras_of(b) == 0) ? 1 : 0;
      5: begin
        all_zero = 1;
        for (int k = 0; k < NB; k++) begin
          if (!is_closed(rc_of(k))) return -1;
          if (cnt_of(k) != 0) all_zero = 0;
        end
        return all_zero;
      end
      default: return -1;
    endcase
  endfunction

  task automatic model_step();
    int v;
    if (rst) begin
      m_rdy = 0; m_pend = 0; m_iss = 0; m_err = 0;
      m_type = 0; m_bank = 0; m_wait = 0; m_stall = 0; m_code = 0;
    end else begin
      if (m_err) begin
        m_err = 0;
      end else if (m_iss) begin
        if (issue_ready) m_iss = 0;
      end else if (m_pend) begin
        m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        v = verdict(m_type, m_bank);
        if (v > 0) begin
          m_pend = 0; m_iss = 1;
        end else if (v < 0) begin
          m_pend = 0; m_err = 1; m_code = 1;
        end else if (m_wait + 1 >= TO) begin
          m_pend = 0; m_err = 1; m_code = 2;
        end else begin
          m_wait++;
        end
      end else if (m_rdy && cmd_valid) begin
        m_pend = 1;
        m_type = int'(cmd_type);
        m_bank = int'(cmd_bank);
        m_wait = 0;
      end
      m_rdy = 1;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("cmd_ready", 32'(cmd_ready), 32'(m_rdy && !m_pend && !m_iss && !m_err));
    chk("issue_valid", 32'(issue_valid), 32'(m_iss));
    chk("err_valid", 32'(err_valid), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    if (m_iss) begin
      chk("issue_type", 32'(issue_type), 32'(m_type));
      chk("issue_bank", 32'(issue_bank), 32'(m_bank));
    end
  end

  task automatic set_cnt(int b, int v);
    tp_cnt_flat[5*b +: 5] = 5'(v);
  endtask
  task automatic set_tras(int b, int v);
    tras_cnt_flat[6*b +: 6] = 6'(v);
  endtask
  task automatic set_rc(int b, int v);
    recode_flat[3*b +: 3] = 3'(v);
  endtask
  task automatic clear_banks();
    tp_cnt_flat = '0;
    tras_cnt_flat = '0;
    recode_flat = '0;
  endtask

  // Presents one command for a single cycle; returns just after the accepting edge.
  task automatic send(int t, int b);
    cmd_valid = 1'b1;
    cmd_type  = 3'(t);
    cmd_bank  = 3'(b);
    tick();
    cmd_valid = 1'b0;
  endtask

  int s0;
  int regime;
  int closed_set[3] = '{0, 2, 7};
  int six_set[6] = '{0, 1, 2, 3, 4, 7};

  initial begin
    // reset state
    tick();
    chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst issue_valid", 32'(issue_valid), 32'd0);
    chk("rst err_valid", 32'(err_valid), 32'd0);
    chk("rst err_code", 32'(err_code), 32'd0);
    chk("rst stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ready after rst", 32'(cmd_ready), 32'd1);

    // ACT to bank 2 waiting for cnt 3,2,1,0
    clear_banks();
    set_rc(2, 2);
    set_cnt(2, 3);
    send(1, 2);
    chk("act hold ready", 32'(cmd_ready), 32'd0);
    for (int k = 2; k >= 0; k--) begin
      tick();
      set_cnt(2, k);
    end
    chk("act not yet", 32'(issue_valid), 32'd0);
    tick();
    chk("act issue_valid", 32'(issue_valid), 32'd1);
    chk("act issue_bank", 32'(issue_bank), 32'd2);
    chk("act issue_type", 32'(issue_type), 32'd1);
    chk("act stall", 32'(stall_cnt), 32'd4);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("act done", 32'(issue_valid), 32'd0);

    // READ to a closed bank
    clear_banks();
    send(2, 5);
    tick();
    chk("rd err_valid", 32'(err_valid), 32'd1);
    chk("rd err_code", 32'(err_code), 32'd1);
    chk("rd no issue", 32'(issue_valid), 32'd0);
    tick();
    chk("rd err one cycle", 32'(err_valid), 32'd0);
    chk("rd code held", 32'(err_code), 32'd1);
    chk("rd ready", 32'(cmd_ready), 32'd1);

    // PRE timeout with tras stuck at 9
    clear_banks();
    set_tras(0, 9);
    s0 = int'(stall_cnt);
    send(4, 0);
    for (int k = 0; k < 254; k++) tick();
    chk("pre no err yet", 32'(err_valid), 32'd0);
    tick();
    chk("pre err_valid", 32'(err_valid), 32'd1);
    chk("pre err_code", 32'(err_code), 32'd2);
    chk("pre stall", 32'(stall_cnt), 32'(s0 + 255));
    set_tras(0, 0);
    tick();

    // REF with one open bank, then with all banks closed
    clear_banks();
    set_rc(7, 3);
    send(5, 0);
    tick();
    chk("ref open err", 32'(err_valid), 32'd1);
    chk("ref open code", 32'(err_code), 32'd1);
    tick();
    for (int b = 0; b < NB; b++) set_rc(b, 2);
    send(5, 3);
    tick();
    chk("ref issue", 32'(issue_valid), 32'd1);
    chk("ref type", 32'(issue_type), 32'd5);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;

    // ISSUE stall then reset mid-hold
    clear_banks();
    send(1, 1);
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("stable valid", 32'(issue_valid), 32'd1);
      chk("stable type", 32'(issue_type), 32'd1);
      chk("stable bank", 32'(issue_bank), 32'd1);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("rst kills issue", 32'(issue_valid), 32'd0);
    chk("rst no err", 32'(err_valid), 32'd0);
    tick();
    chk("rst hold no err", 32'(err_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready low after rst", 32'(cmd_ready), 32'd0);
    tick();
    chk("ready back", 32'(cmd_ready), 32'd1);

    // randomized traffic
    regime = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (i % 250 == 0) regime = $urandom_range(0, 2);
      rst = ($urandom_range(0, 399) == 0);
      cmd_valid = 1'($urandom_range(0, 1));
      s0 = $urandom_range(0, 15);
      cmd_type = (s0 < 13) ? 3'(1 + s0 % 5) : 3'($urandom_range(0, 7));
      cmd_bank = 3'($urandom_range(0, 7));
      issue_ready = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < NB; b++) begin
        case (regime)
          0: set_rc(b, closed_set[$urandom_range(0, 2)]);
          1: set_rc(b, six_set[$urandom_range(0, 5)]);
          default: set_rc(b, $urandom_range(0, 7));
        endcase
        set_cnt(b, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 31) : 0);
        set_tras(b, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 63) : 0);
      end
    end
    rst = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
